elevator_alert_ctrl: RTL and testbench
======================================

ELEVATOR_ALERT_CTRL -- requirements
Module: elevator_alert_ctrl

Interface
REQ-001 Parameter N_DOORS, default 2, number of independently monitored doors (1..8).
REQ-002 Parameter DOOR_TIMEOUT_CYC, default 555555, consecutive open cycles before door alert (>=2).
REQ-003 Parameter SNOOZE_CYC, default 555555, open cycles after acknowledge before the door alert re-asserts (>=2).
REQ-004 Parameter WEIGHT_W, default 13, width of the load measurement in kg.
REQ-005 Parameter WEIGHT_LIMIT, default 4500, overload threshold in kg.
REQ-006 Parameter WEIGHT_HYST, default 100, kg below WEIGHT_LIMIT required to clear overload (< WEIGHT_LIMIT).
REQ-007 Parameter DEBOUNCE_CYC, default 16, consecutive cycles a weight condition must hold before the overload state changes (>=1).
REQ-008 clk  input  1  single clock; all state changes on the rising edge.
REQ-009 rst  input  1  reset, synchronous, active-high.
REQ-010 door_open  input  N_DOORS  bit i: 1 = door i open, 0 = closed.
REQ-011 weight_kg  input  WEIGHT_W  unsigned car load, sampled every cycle.
REQ-012 alert_ack  input  1  single-cycle acknowledge; silences every door currently in ALERT.
REQ-013 door_alert  output  N_DOORS  bit i high while door i is in ALERT.
REQ-014 weight_alert  output  1  high while overload is latched.
REQ-015 any_alert  output  1  OR of all door_alert bits and weight_alert.
REQ-016 motion_inhibit  output  1  high when any door_open bit is 1 or weight_alert is 1.
REQ-017 alert_events  output  8  saturating count of door CLOSED/TIMING->ALERT and SNOOZE->ALERT entries, all doors.

Function
REQ-018 All outputs are registered; motion_inhibit and any_alert reflect state as of the previous edge (one-cycle latency).
REQ-019 Each door runs FSM CLOSED, TIMING, ALERT, SNOOZE with a private cycle counter of clog2(max(DOOR_TIMEOUT_CYC,SNOOZE_CYC))+1 bits.
REQ-020 Any state with door_open[i]=0 at an edge goes to CLOSED and clears its counter, overriding every other transition.
REQ-021 CLOSED -> TIMING on an edge sampling door_open[i]=1; counter loads 1.
REQ-022 TIMING increments per open edge; at the DOOR_TIMEOUT_CYC-th consecutive open edge it enters ALERT and door_alert[i] rises.
REQ-023 ALERT holds until close or alert_ack=1; ack moves to SNOOZE, door_alert[i] falls on that edge, counter loads 1.
REQ-024 SNOOZE increments per open edge; at the SNOOZE_CYC-th open edge it returns to ALERT.
REQ-025 alert_ack in CLOSED, TIMING or SNOOZE has no effect; ack and door close on the same edge -> CLOSED.
REQ-026 Overload sets when weight_kg > WEIGHT_LIMIT for DEBOUNCE_CYC consecutive edges.
REQ-027 Overload clears when weight_kg < WEIGHT_LIMIT-WEIGHT_HYST for DEBOUNCE_CYC consecutive edges.
REQ-028 Weight in the hysteresis band, or a condition run shorter than DOOR_TIMEOUT-independent DEBOUNCE_CYC, holds the current overload state and restarts the debounce run.
REQ-029 weight_alert is not acknowledgeable; alert_ack never affects it.
REQ-030 alert_events increments by the number of doors entering ALERT on that edge, saturating at 255.

Reset
REQ-031 rst=1 at an edge forces all doors to CLOSED, all counters to 0, overload cleared, alert_events=0, all outputs 0, regardless of inputs.
REQ-032 After reset release, a door already open starts TIMING on the first edge with rst=0; counting restarts mid-operation.

Structure
REQ-033 Package elevator_alert_pkg holds the door FSM state enum and default parameter constants.
REQ-034 Sub-module door_alert_timer implements one door FSM and counter; instantiated N_DOORS times via generate.
REQ-035 Weight debounce, event counter and output OR-ing live in the top module.

Verification (DOOR_TIMEOUT_CYC=10, SNOOZE_CYC=5, DEBOUNCE_CYC=4, N_DOORS=2)
REQ-036 door_open=01 held 10 edges -> door_alert=01 after 10th edge, alert_events=1, any_alert=1 next cycle; door_open=00 -> door_alert=00.
REQ-037 Door 0 open 9 edges, closed 1, open 9 -> door_alert stays 0.
REQ-038 Door 1 in ALERT, alert_ack pulse -> door_alert=00 next edge; 5 more open edges -> door_alert=10, alert_events=2.
REQ-039 weight_kg=4501 for 3 edges then 4450 -> weight_alert 0; 4501 for 4 edges -> weight_alert=1; 4450 for 10 edges -> stays 1; 4399 for 4 edges -> 0.
REQ-040 Both doors alerting, rst=1 one edge -> all outputs 0; rst=0 with doors still open -> door_alert after 10 further edges.
REQ-041 alert_events preloaded by 255 alert entries -> further alerts leave it at 255.

Source files
------------

// File: rtl/elevator_alert_pkg.sv
// Shared types and default constants for the elevator alert controller.
// Door FSM state encoding plus parameter defaults used by all modules.
package elevator_alert_pkg;

  typedef enum logic [1:0] {
    DOOR_CLOSED = 2'd0,
    DOOR_TIMING = 2'd1,
    DOOR_ALERT  = 2'd2,
    DOOR_SNOOZE = 2'd3
  } door_state_e;

  localparam int DEF_N_DOORS      = 2;
  localparam int DEF_DOOR_TIMEOUT = 555555;
  localparam int DEF_SNOOZE       = 555555;
  localparam int DEF_WEIGHT_W     = 13;
  localparam int DEF_WEIGHT_LIMIT = 4500;
  localparam int DEF_WEIGHT_HYST  = 100;
  localparam int DEF_DEBOUNCE     = 16;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/door_alert_timer.sv
// Per-door open timer: CLOSED -> TIMING -> ALERT, with ack-driven SNOOZE.
// Closing the door always returns to CLOSED and clears the counter.
module door_alert_timer
  import elevator_alert_pkg::*;
#(
  parameter int DOOR_TIMEOUT_CYC = DEF_DOOR_TIMEOUT,
  parameter int SNOOZE_CYC       = DEF_SNOOZE
) (
  input  logic clk,
  input  logic rst,
  input  logic door_open,
  input  logic alert_ack,
  output logic alert,
  output logic alert_next,
  output logic alert_enter
);

  localparam int MAXC = max2(DOOR_TIMEOUT_CYC, SNOOZE_CYC);
  localparam int CW   = $clog2(MAXC) + 1;

  // The entry edge loads 1, so TIMING fires one count early;
  // SNOOZE counts edges after the ack edge.
  localparam logic [CW-1:0] T_LAST = CW'(DOOR_TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] S_LAST = CW'(SNOOZE_CYC);

  door_state_e     state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!door_open) begin
      state_d = DOOR_CLOSED;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        DOOR_CLOSED: begin
          state_d = DOOR_TIMING;
          cnt_d   = CW'(1);
        end
        DOOR_TIMING: begin
          if (cnt_q == T_LAST) begin
            state_d = DOOR_ALERT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DOOR_ALERT: begin
          if (alert_ack) begin
            state_d = DOOR_SNOOZE;
            cnt_d   = CW'(1);
          end
        end
        DOOR_SNOOZE: begin
          if (cnt_q == S_LAST) begin
            state_d = DOOR_ALERT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = DOOR_CLOSED;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DOOR_CLOSED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign alert      = (state_q == DOOR_ALERT);
  assign alert_next = !rst && (state_d == DOOR_ALERT);
  assign alert_enter = alert_next && (state_q != DOOR_ALERT);

endmodule

// File: rtl/elevator_alert_ctrl.sv
// Elevator alert controller: per-door open timers, debounced overload
// detection, alert event counter and registered summary outputs.
module elevator_alert_ctrl
  import elevator_alert_pkg::*;
#(
  parameter int N_DOORS          = DEF_N_DOORS,
  parameter int DOOR_TIMEOUT_CYC = DEF_DOOR_TIMEOUT,
  parameter int SNOOZE_CYC       = DEF_SNOOZE,
  parameter int WEIGHT_W         = DEF_WEIGHT_W,
  parameter int WEIGHT_LIMIT     = DEF_WEIGHT_LIMIT,
  parameter int WEIGHT_HYST      = DEF_WEIGHT_HYST,
  parameter int DEBOUNCE_CYC     = DEF_DEBOUNCE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_DOORS-1:0]  door_open,
  input  logic [WEIGHT_W-1:0] weight_kg,
  input  logic                alert_ack,
  output logic [N_DOORS-1:0]  door_alert,
  output logic                weight_alert,
  output logic                any_alert,
  output logic                motion_inhibit,
  output logic [7:0]          alert_events
);

  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [WEIGHT_W-1:0] SET_TH = WEIGHT_W'(WEIGHT_LIMIT);
  localparam logic [WEIGHT_W-1:0] CLR_TH =
    WEIGHT_W'(WEIGHT_LIMIT - WEIGHT_HYST);

  logic [N_DOORS-1:0] alert_now;
  logic [N_DOORS-1:0] alert_nxt;
  logic [N_DOORS-1:0] enter;

  for (genvar g = 0; g < N_DOORS; g++) begin : g_door
    door_alert_timer #(
      .DOOR_TIMEOUT_CYC (DOOR_TIMEOUT_CYC),
      .SNOOZE_CYC       (SNOOZE_CYC)
    ) u_door (
      .clk         (clk),
      .rst         (rst),
      .door_open   (door_open[g]),
      .alert_ack   (alert_ack),
      .alert       (alert_now[g]),
      .alert_next  (alert_nxt[g]),
      .alert_enter (enter[g])
    );
  end

  logic          ovl_q, ovl_d;
  logic [DW-1:0] run_q, run_d;
  logic [DW-1:0] run_inc;
  logic          want;

  // The run only counts toward flipping the current state; any other
  // weight restarts it.
  always_comb begin
    run_inc = run_q + 1'b1;
    want    = ovl_q ? (weight_kg < CLR_TH) : (weight_kg > SET_TH);
    ovl_d   = ovl_q;
    run_d   = '0;
    if (want) begin
      if (run_inc == DW'(DEBOUNCE_CYC)) begin
        ovl_d = !ovl_q;
      end else begin
        run_d = run_inc;
      end
    end
  end

  logic [3:0] n_enter;
  logic [8:0] evt_sum;
  logic [7:0] evt_q, evt_d;

  always_comb begin
    n_enter = '0;
    for (int i = 0; i < N_DOORS; i++) begin
      n_enter = n_enter + 4'(enter[i]);
    end
    evt_sum = {1'b0, evt_q} + 9'(n_enter);
    evt_d   = evt_sum[8] ? 8'hFF : evt_sum[7:0];
  end

  logic mi_q, mi_d;
  logic any_q, any_d;

  always_comb begin
    mi_d  = (|door_open) || ovl_d;
    any_d = (|alert_nxt) || ovl_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovl_q <= 1'b0;
      run_q <= '0;
      evt_q <= '0;
      mi_q  <= 1'b0;
      any_q <= 1'b0;
    end else begin
      ovl_q <= ovl_d;
      run_q <= run_d;
      evt_q <= evt_d;
      mi_q  <= mi_d;
      any_q <= any_d;
    end
  end

  assign door_alert     = alert_now;
  assign weight_alert   = ovl_q;
  assign any_alert      = any_q;
  assign motion_inhibit = mi_q;
  assign alert_events   = evt_q;

endmodule

// File: tb/tb_elevator_alert_ctrl.sv
// Bench for elevator_alert_ctrl: vector table, saturation sequence and
// randomized traffic against a run-length reference model.
module tb_elevator_alert_ctrl;

  localparam int ND  = 2;
  localparam int TO  = 10;
  localparam int SN  = 5;
  localparam int DB  = 4;
  localparam int WW  = 13;
  localparam int LIM = 4500;
  localparam int HY  = 100;

  logic          clk = 1'b0;
  logic          rst;
  logic [ND-1:0] door_open;
  logic [WW-1:0] weight_kg;
  logic          alert_ack;
  logic [ND-1:0] door_alert;
  logic          weight_alert;
  logic          any_alert;
  logic          motion_inhibit;
  logic [7:0]    alert_events;

  always #5 clk = ~clk;

  elevator_alert_ctrl #(
    .N_DOORS          (ND),
    .DOOR_TIMEOUT_CYC (TO),
    .SNOOZE_CYC       (SN),
    .WEIGHT_W         (WW),
    .WEIGHT_LIMIT     (LIM),
    .WEIGHT_HYST      (HY),
    .DEBOUNCE_CYC     (DB)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .door_open      (door_open),
    .weight_kg      (weight_kg),
    .alert_ack      (alert_ack),
    .door_alert     (door_alert),
    .weight_alert   (weight_alert),
    .any_alert      (any_alert),
    .motion_inhibit (motion_inhibit),
    .alert_events   (alert_events)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference model: open-run lengths against an alert deadline,
  // and run lengths of over/under weight samples.
  int  run [ND];
  int  dl  [ND];
  bit  al  [ND];
  bit  m_ovl;
  int  orun;
  int  urun;
  int  m_ev;
  bit  m_mi;
  bit  m_any;

  task automatic model_step(input bit r, input bit [1:0] d, input int w,
                            input bit a);
    if (r) begin
      for (int i = 0; i < ND; i++) begin
        run[i] = 0;
        dl[i]  = TO;
        al[i]  = 0;
      end
      m_ovl = 0; orun = 0; urun = 0; m_ev = 0; m_mi = 0; m_any = 0;
      return;
    end
    for (int i = 0; i < ND; i++) begin
      if (!d[i]) begin
        run[i] = 0;
        dl[i]  = TO;
        al[i]  = 0;
      end else begin
        run[i]++;
        if (a && al[i]) begin
          dl[i] = run[i] + SN;
          al[i] = 0;
        end else if (!al[i] && run[i] >= dl[i]) begin
          al[i] = 1;
          m_ev++;
        end
      end
    end
    if (m_ev > 255) m_ev = 255;
    orun = (w > LIM) ? orun + 1 : 0;
    urun = (w < LIM - HY) ? urun + 1 : 0;
    if (!m_ovl && orun >= DB) m_ovl = 1;
    else if (m_ovl && urun >= DB) m_ovl = 0;
    m_mi  = (d != 0) || m_ovl;
    m_any = m_ovl;
    for (int i = 0; i < ND; i++) m_any = m_any || al[i];
  endtask

  task automatic step(input bit r, input bit [1:0] d, input int w,
                      input bit a);
    rst       = r;
    door_open = d;
    weight_kg = WW'(w);
    alert_ack = a;
    @(posedge clk);
    model_step(r, d, w, a);
    #1;
  endtask

  typedef struct {
    int       rep;
    bit       r;
    bit [1:0] d;
    int       w;
    bit       a;
    bit [1:0] da;
    bit       wa;
    bit       an;
    bit       mi;
    int       ev;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int rep, input bit r, input bit [1:0] d,
                     input int w, input bit a, input bit [1:0] da,
                     input bit wa, input bit an, input bit mi,
                     input int ev);
    vec_t v;
    v.rep = rep; v.r = r; v.d = d; v.w = w; v.a = a;
    v.da = da; v.wa = wa; v.an = an; v.mi = mi; v.ev = ev;
    tbl.push_back(v);
  endtask

  initial begin
    rst = 1'b1;
    door_open = '0;
    weight_kg = '0;
    alert_ack = 1'b0;

    //   rep r  door   w    a   da    wa an mi ev
    add(1,  1, 2'b11, 5000, 1, 2'b00, 0, 0, 0, 0);
    add(9,  0, 2'b01, 0,    0, 2'b00, 0, 0, 1, 0);
    add(1,  0, 2'b01, 0,    0, 2'b01, 0, 1, 1, 1);
    add(1,  0, 2'b00, 0,    0, 2'b00, 0, 0, 0, 1);
    add(9,  0, 2'b01, 0,    0, 2'b00, 0, 0, 1, 1);
    add(1,  0, 2'b00, 0,    0, 2'b00, 0, 0, 0, 1);
    add(9,  0, 2'b01, 0,    0, 2'b00, 0, 0, 1, 1);
    add(1,  0, 2'b00, 0,    0, 2'b00, 0, 0, 0, 1);
    add(10, 0, 2'b10, 0,    0, 2'b10, 0, 1, 1, 2);
    add(1,  0, 2'b10, 0,    1, 2'b00, 0, 0, 1, 2);
    add(4,  0, 2'b10, 0,    0, 2'b00, 0, 0, 1, 2);
    add(1,  0, 2'b10, 0,    0, 2'b10, 0, 1, 1, 3);
    add(1,  0, 2'b00, 0,    0, 2'b00, 0, 0, 0, 3);
    add(3,  0, 2'b00, 4501, 0, 2'b00, 0, 0, 0, 3);
    add(1,  0, 2'b00, 4450, 0, 2'b00, 0, 0, 0, 3);
    add(3,  0, 2'b00, 4501, 0, 2'b00, 0, 0, 0, 3);
    add(1,  0, 2'b00, 4501, 0, 2'b00, 1, 1, 1, 3);
    add(10, 0, 2'b00, 4450, 0, 2'b00, 1, 1, 1, 3);
    add(3,  0, 2'b00, 4399, 0, 2'b00, 1, 1, 1, 3);
    add(1,  0, 2'b00, 4399, 0, 2'b00, 0, 0, 0, 3);
    add(6,  0, 2'b00, 4500, 0, 2'b00, 0, 0, 0, 3);
    add(4,  0, 2'b00, 5000, 0, 2'b00, 1, 1, 1, 3);
    add(1,  0, 2'b00, 5000, 1, 2'b00, 1, 1, 1, 3);
    add(4,  0, 2'b00, 4400, 0, 2'b00, 1, 1, 1, 3);
    add(4,  0, 2'b00, 0,    0, 2'b00, 0, 0, 0, 3);
    add(10, 0, 2'b11, 0,    0, 2'b11, 0, 1, 1, 5);
    add(1,  1, 2'b11, 0,    0, 2'b00, 0, 0, 0, 0);
    add(9,  0, 2'b11, 0,    0, 2'b00, 0, 0, 1, 0);
    add(1,  0, 2'b11, 0,    0, 2'b11, 0, 1, 1, 2);
    add(1,  0, 2'b00, 0,    1, 2'b00, 0, 0, 0, 2);
    add(9,  0, 2'b01, 0,    1, 2'b00, 0, 0, 1, 2);
    add(1,  0, 2'b01, 0,    0, 2'b01, 0, 1, 1, 3);
    add(1,  0, 2'b00, 0,    0, 2'b00, 0, 0, 0, 3);

    for (int i = 0; i < tbl.size(); i++) begin
      for (int k = 0; k < tbl[i].rep; k++)
        step(tbl[i].r, tbl[i].d, tbl[i].w, tbl[i].a);
      chk($sformatf("v%0d_door_alert", i), 32'(door_alert),
          32'(tbl[i].da));
      chk($sformatf("v%0d_weight_alert", i), 32'(weight_alert),
          32'(tbl[i].wa));
      chk($sformatf("v%0d_any_alert", i), 32'(any_alert),
          32'(tbl[i].an));
      chk($sformatf("v%0d_motion_inhibit", i), 32'(motion_inhibit),
          32'(tbl[i].mi));
      chk($sformatf("v%0d_alert_events", i), 32'(alert_events),
          32'(tbl[i].ev));
    end

    // Event counter saturation: 254 entries, then a double entry.
    step(1, 2'b00, 0, 0);
    for (int n = 0; n < 127; n++) begin
      repeat (10) step(0, 2'b11, 0, 0);
      step(0, 2'b00, 0, 0);
    end
    chk("sat_254", 32'(alert_events), 32'd254);
    repeat (10) step(0, 2'b11, 0, 0);
    chk("sat_255", 32'(alert_events), 32'd255);
    chk("sat_door_alert", 32'(door_alert), 32'd3);
    step(0, 2'b00, 0, 0);
    repeat (10) step(0, 2'b01, 0, 0);
    chk("sat_hold", 32'(alert_events), 32'd255);
    chk("sat_door0", 32'(door_alert), 32'd1);

    // Randomized traffic against the reference model.
    begin
      bit [1:0] d;
      int       w;
      int       wsel [9];
      wsel = '{0, 4398, 4399, 4400, 4450, 4500, 4501, 5000, 8191};
      d = 2'b00;
      w = 0;
      step(1, d, w, 0);
      for (int c = 0; c < 3000; c++) begin
        bit r, a;
        bit [1:0] m_da;
        for (int i = 0; i < ND; i++)
          if ($urandom_range(0, 11) == 0) d[i] = ~d[i];
        if ($urandom_range(0, 5) == 0) w = wsel[$urandom_range(0, 8)];
        a = ($urandom_range(0, 7) == 0);
        r = ($urandom_range(0, 399) == 0);
        step(r, d, w, a);
        for (int i = 0; i < ND; i++) m_da[i] = al[i];
        chk($sformatf("rnd%0d_door_alert", c), 32'(door_alert),
            32'(m_da));
        chk($sformatf("rnd%0d_weight_alert", c), 32'(weight_alert),
            32'(m_ovl));
        chk($sformatf("rnd%0d_any_alert", c), 32'(any_alert),
            32'(m_any));
        chk($sformatf("rnd%0d_motion_inhibit", c),
            32'(motion_inhibit), 32'(m_mi));
        chk($sformatf("rnd%0d_alert_events", c), 32'(alert_events),
            32'(m_ev));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
